// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between the WB stage and a long-latency unit, with busy scoreboard, hazard stall and starvation guard
//
// Ports:
//   clock, reset                         clock; asynchronous active-high reset
//   pipe_wr_en, pipe_waddr, pipe_wdata   WB-stage write request (never back-pressured)
//   lu_valid, lu_waddr, lu_wdata         long-unit write request
//   lu_ready                             long-unit write accepted this cycle
//   iss_valid, iss_rd                    long op issued; its destination becomes busy
//   chk_valid, chk_rs1/rs2/rd            decode registers checked against the scoreboard
//   hz_stall                             decode must stall
//   pipe_hold                            WB stage must freeze (forced long-unit grant)
//   rf_reg_wr, rf_waddr, rf_wdata        register-file write port (committed on negedge)
//   busy_vec                             scoreboard, bit 0 always 0
//
// Optional build macro WB_BYPASS_EN: the register released by this cycle's long-unit
// grant no longer stalls decode in the same cycle.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pipe_wr_en,
  input  logic [4:0]      pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            lu_valid,
  input  logic [4:0]      lu_waddr,
  input  logic [XLEN-1:0] lu_wdata,
  output logic            lu_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic            chk_valid,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hz_stall,
  output logic            pipe_hold,
  output logic            rf_reg_wr,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy_vec
);
  typedef enum logic {NORMAL, FORCE} state_t;
  state_t      state, state_n;
  logic [3:0]  wait_cnt, wait_cnt_n;
  logic [31:0] busy, busy_n, busy_hz;
  logic        grant_pipe, grant_lu;
  // Outputs are gated by reset so they drop immediately on an asynchronous reset,
  // even though the combinational paths would otherwise still see live requests.
  always_comb begin
    state_n    = NORMAL;
    wait_cnt_n = '0;
    pipe_hold  = 1'b0;
    lu_ready   = 1'b0;
    grant_pipe = 1'b0;
    if (!reset) begin
      if (state == FORCE) begin
        pipe_hold = 1'b1;
        lu_ready  = lu_valid;
      end else begin
        grant_pipe = pipe_wr_en;
        lu_ready   = lu_valid && !pipe_wr_en;
        if (lu_valid && !lu_ready) begin
          wait_cnt_n = wait_cnt + 4'd1;
          state_n    = (wait_cnt_n == 4'(MAX_WAIT)) ? FORCE : NORMAL;
        end
      end
    end
  end
  assign grant_lu  = lu_ready;
  assign rf_waddr  = grant_lu ? lu_waddr : grant_pipe ? pipe_waddr : 5'd0;
  assign rf_wdata  = grant_lu ? lu_wdata : grant_pipe ? pipe_wdata : '0;
  assign rf_reg_wr = (grant_lu || grant_pipe) && (rf_waddr != 5'd0);
  // Set is applied after clear so an issue to the register being released wins.
  always_comb begin
    busy_n = busy;
    if (grant_lu) busy_n[lu_waddr] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) busy_n[iss_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      wait_cnt <= '0;
      busy     <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      busy     <= busy_n;
    end
  end
  assign busy_vec = busy;
`ifdef WB_BYPASS_EN
  // The register file commits on negedge, so the value decode reads this cycle is already current.
  assign busy_hz = busy & ~(grant_lu ? (32'd1 << lu_waddr) : 32'd0);
`else
  assign busy_hz = busy;
`endif
  assign hz_stall = !reset && chk_valid && (busy_hz[chk_rs1] || busy_hz[chk_rs2] || busy_hz[chk_rd]);
  // A WB write during a forced grant is silently lost; flag it in simulation.
  force_no_pipe: assert property (@(posedge clock) disable iff (reset) (state == FORCE) |-> !pipe_wr_en);
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writers: the in-order pipeline writeback stage and a long-latency unit (load/mul-div) that uses a valid/ready handshake.
- Keeps a busy scoreboard of destination registers owned by outstanding long ops and raises a decode hazard stall against them.
- Guarantees forward progress for the long-latency unit with a starvation counter and a pipeline hold.
- Sits between the WB stage, the long-latency unit, decode and the register file.

Parameters:
- XLEN, 32, data width of the write port.
- MAX_WAIT, 4, consecutive cycles of lu_valid without a grant before a forced grant. Legal range 1..15.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pipe_wr_en  in  1  pipeline WB write request; cannot be back-pressured
pipe_waddr  in  5  pipeline destination register
pipe_wdata  in  XLEN  pipeline write data
lu_valid  in  1  long-unit write request
lu_waddr  in  5  long-unit destination register
lu_wdata  in  XLEN  long-unit write data
lu_ready  out  1  long-unit write accepted this cycle
iss_valid  in  1  long op issued this cycle
iss_rd  in  5  destination of the issued long op
chk_valid  in  1  decode has a valid instruction to check
chk_rs1  in  5  decode source register 1
chk_rs2  in  5  decode source register 2
chk_rd  in  5  decode destination register
hz_stall  out  1  decode must stall
pipe_hold  out  1  WB stage must freeze and drive pipe_wr_en=0 this cycle
rf_reg_wr  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data
busy_vec  out  32  scoreboard, one bit per register; bit 0 is always 0

Behaviour:
- One clock, clock. reset is asynchronous and active-high. While reset is high:
  - state=NORMAL, wait_cnt=0, busy_vec=0.
  - pipe_hold=0, lu_ready=0, rf_reg_wr=0, hz_stall=0.
  - An outstanding lu request is dropped; the long unit re-presents it after reset.
- Write-port outputs are combinational, with zero latency from request to rf_* outputs. The register file commits them on the following negedge.
- FSM, state NORMAL:
  - If pipe_wr_en=1: grant pipe, lu_ready=0.
  - Otherwise, if lu_valid=1: grant lu, lu_ready=1.
  - pipe_hold=0.
- wait_cnt (4 bits, registered):
  - Increments on each cycle with lu_valid=1 and lu_ready=0.
  - Clears on any lu grant, or when lu_valid=0.
  - When it increments to MAX_WAIT, the next state is FORCE.
- FSM, state FORCE:
  - pipe_hold=1 (Moore output).
  - Grant lu unconditionally: lu_ready=lu_valid.
  - Always returns to NORMAL next cycle with wait_cnt=0.
  - pipe_wr_en=1 in FORCE is a protocol violation: the lu grant still wins, the pipe write is lost, and a simulation assertion fires.
  - lu_valid=0 in FORCE (request withdrawn): nothing is written; return to NORMAL.
- Grant mux:
  - rf_waddr/rf_wdata come from the granted source.
  - rf_reg_wr = grant && (granted waddr != 0).
  - With no grant: rf_reg_wr=0, rf_waddr=0, rf_wdata=0.
  - An lu write to x0 is still handshaken (lu_ready=1).
- Scoreboard (registered):
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - An lu grant clears busy[lu_waddr].
  - Set and clear of the same register in the same cycle: set wins.
  - Setting an already-busy bit keeps it 1; no counting.
  - Clearing a bit that is not busy is harmless.
- Hazard:
  - hz_stall = chk_valid && (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]).
  - Register 0 never hits.
  - Including chk_rd prevents WAW ordering violations between pipe and lu writes.
- pipe writes never touch the scoreboard.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: hz_stall masks the register being cleared by this cycle's lu grant (lu_ready && lu_waddr matches). Decode can proceed in the same cycle the long result is written, because the register file writes on negedge.
- Undefined: hz_stall uses only the registered busy_vec, so release costs one extra stall cycle.
- busy_vec timing is identical in both builds.

Test Plan:
- Reset mid-operation: busy_vec=0x0000_0024 with lu_valid=1, then assert reset asynchronously mid-cycle -> busy_vec, pipe_hold, lu_ready and rf_reg_wr go to 0 immediately without a clock edge.
- Priority: pipe_wr_en=1 (x5, 0xAAAA_0001) and lu_valid=1 (x6, 0x1234) in the same cycle -> rf writes x5=0xAAAA_0001, lu_ready=0. The next cycle with pipe idle -> x6=0x1234, lu_ready=1.
- Starvation (MAX_WAIT=4): pipe_wr_en=1 continuously with lu_valid=1 -> after 4 denied cycles, pipe_hold=1 for exactly 1 cycle. In that cycle the lu write to x9 commits and lu_ready=1; NORMAL resumes the cycle after.
- Scoreboard: iss_valid with iss_rd=7 -> busy_vec[7]=1 next cycle. Decode with chk_rs2=7 -> hz_stall=1. lu grant to x7 -> bit clears next cycle. Stall drops 1 cycle after the grant when WB_BYPASS_EN is undefined, and in the grant cycle when it is defined.
- Same-cycle set and clear: lu grant to x3 plus iss_valid with iss_rd=3 -> busy_vec[3] stays 1.
- x0 handling: iss_rd=0 -> busy_vec unchanged. lu write to x0 -> lu_ready=1, rf_reg_wr=0.
